// File: rtl/led_blink_pkg.sv
// rtl/led_blink_pkg.sv - mode encodings and register map shared by the LED controller
package led_blink_pkg;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

    localparam int A_PRESC    = 0;
    localparam int A_STATUS   = 1;
    localparam int A_CH_BASE  = 4;
    localparam int CH_STRIDE  = 4;
    localparam int OFF_CTRL   = 0;
    localparam int OFF_PERIOD = 1;
    localparam int OFF_DUTY   = 2;

endpackage

// File: rtl/led_channel.sv
// rtl/led_channel.sv - one LED channel: mode/period/duty registers, blink counter and PWM phase
module led_channel
    import led_blink_pkg::*;
#(
    parameter int CNT_W = 24,
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic             wr_ctrl,
    input  logic             wr_period,
    input  logic             wr_duty,
    input  logic [CNT_W-1:0] wdata,
    output logic [1:0]       ctrl,
    output logic [CNT_W-1:0] period,
    output logic [PWM_W-1:0] duty,
    output logic             led
);

    mode_e            ctrl_q, ctrl_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [PWM_W-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] bc_q, bc_d;
    logic [PWM_W-1:0] ph_q, ph_d;
    logic             bst_q, bst_d;
    logic             led_q, led_d;

    // Next-state: tick-driven counting first, then register writes override it
    always_comb begin
        ctrl_d   = ctrl_q;
        period_d = period_q;
        duty_d   = duty_q;
        bc_d     = bc_q;
        ph_d     = ph_q;
        bst_d    = bst_q;

        if (tick && ctrl_q == MODE_BLINK) begin
            if (bc_q == period_q) begin
                bc_d  = '0;
                bst_d = ~bst_q;
            end else begin
                bc_d = bc_q + CNT_W'(1);
            end
        end
        // Phase wraps naturally at 2^PWM_W
        if (tick && ctrl_q == MODE_PWM) begin
            ph_d = ph_q + PWM_W'(1);
        end

        // A period write restarts the current half-period without toggling
        if (wr_period) begin
            period_d = wdata;
            bc_d     = '0;
            bst_d    = bst_q;
        end
        if (wr_duty) begin
            duty_d = wdata[PWM_W-1:0];
        end
        // Any mode write restarts the channel from a dark state
        if (wr_ctrl) begin
            ctrl_d = mode_e'(wdata[1:0]);
            bc_d   = '0;
            ph_d   = '0;
            bst_d  = 1'b0;
        end

        case (ctrl_d)
            MODE_OFF:   led_d = 1'b0;
            MODE_ON:    led_d = 1'b1;
            MODE_BLINK: led_d = bst_d;
            MODE_PWM:   led_d = (ph_d < duty_d);
            default:    led_d = 1'b0;
        endcase
    end

    // Channel state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q   <= MODE_OFF;
            period_q <= '0;
            duty_q   <= '0;
            bc_q     <= '0;
            ph_q     <= '0;
            bst_q    <= 1'b0;
            led_q    <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            period_q <= period_d;
            duty_q   <= duty_d;
            bc_q     <= bc_d;
            ph_q     <= ph_d;
            bst_q    <= bst_d;
            led_q    <= led_d;
        end
    end

    assign ctrl   = ctrl_q;
    assign period = period_q;
    assign duty   = duty_q;
    assign led    = led_q;

endmodule

// File: rtl/led_blink_ctrl.sv
// rtl/led_blink_ctrl.sv - multi-channel LED controller top; LED_ACTIVE_LOW_EN inverts the led pins
module led_blink_ctrl
    import led_blink_pkg::*;
#(
    parameter int               N_CH      = 4,
    parameter int               CNT_W     = 24,
    parameter int               PWM_W     = 8,
    parameter int               ADDR_W    = 5,
    parameter logic [CNT_W-1:0] PRESC_RST = 24'd49999
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              rvalid,
    output logic [N_CH-1:0]   led,
    output logic              tick
);

    logic [CNT_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0] pc_q, pc_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             rvalid_q, rvalid_d;
    logic             tick_int;

    logic [N_CH-1:0]  led_log;
    logic [1:0]       ch_ctrl   [N_CH];
    logic [CNT_W-1:0] ch_period [N_CH];
    logic [PWM_W-1:0] ch_duty   [N_CH];

    logic             in_ch;
    logic [ADDR_W-1:0] addr_rel;
    logic [ADDR_W-1:0] ch_idx;
    logic [ADDR_W-1:0] ch_off;
    logic [31:0]      rd_word;
    logic             unused_wdata_hi;

    assign unused_wdata_hi = ^wdata[31:CNT_W];

    // Split a word address into channel index and register offset
    always_comb begin
        in_ch    = (addr >= ADDR_W'(A_CH_BASE));
        addr_rel = addr - ADDR_W'(A_CH_BASE);
        ch_idx   = addr_rel / ADDR_W'(CH_STRIDE);
        ch_off   = addr_rel % ADDR_W'(CH_STRIDE);
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic sel;
        assign sel = wr_en && in_ch && (ch_idx == ADDR_W'(c));

        led_channel #(
            .CNT_W (CNT_W),
            .PWM_W (PWM_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst),
            .tick      (tick_int),
            .wr_ctrl   (sel && ch_off == ADDR_W'(OFF_CTRL)),
            .wr_period (sel && ch_off == ADDR_W'(OFF_PERIOD)),
            .wr_duty   (sel && ch_off == ADDR_W'(OFF_DUTY)),
            .wdata     (wdata[CNT_W-1:0]),
            .ctrl      (ch_ctrl[c]),
            .period    (ch_period[c]),
            .duty      (ch_duty[c]),
            .led       (led_log[c])
        );
    end

    // Read mux over current register contents; a same-cycle write is not yet visible
    always_comb begin
        rd_word = '0;
        if (addr == ADDR_W'(A_PRESC)) begin
            rd_word = 32'(presc_q);
        end else if (addr == ADDR_W'(A_STATUS)) begin
            rd_word = 32'(led_log);
        end else if (in_ch) begin
            for (int c = 0; c < N_CH; c++) begin
                if (ch_idx == ADDR_W'(c)) begin
                    if (ch_off == ADDR_W'(OFF_CTRL)) begin
                        rd_word = 32'(ch_ctrl[c]);
                    end else if (ch_off == ADDR_W'(OFF_PERIOD)) begin
                        rd_word = 32'(ch_period[c]);
                    end else if (ch_off == ADDR_W'(OFF_DUTY)) begin
                        rd_word = 32'(ch_duty[c]);
                    end
                end
            end
        end
    end

    // Prescaler and bus-response next state
    always_comb begin
        tick_int = (pc_q == presc_q);
        pc_d     = tick_int ? '0 : pc_q + CNT_W'(1);
        presc_d  = presc_q;
        if (wr_en && addr == ADDR_W'(A_PRESC)) begin
            presc_d = wdata[CNT_W-1:0];
            pc_d    = '0;
        end
        rdata_d  = rd_en ? rd_word : rdata_q;
        rvalid_d = rd_en;
    end

    // Prescaler and bus-response registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q  <= PRESC_RST;
            pc_q     <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            pc_q     <= pc_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
    assign tick   = tick_int;

`ifdef LED_ACTIVE_LOW_EN
    assign led = ~led_log;
`else
    assign led = led_log;
`endif

endmodule

// File: tb/tb_led_blink_ctrl.sv
// tb/tb_led_blink_ctrl.sv - scoreboard bench for led_blink_ctrl against a tick-counting reference model
module tb_led_blink_ctrl;

    localparam int N_CH      = 4;
    localparam int ADDR_W    = 5;
    localparam int PRESC_RST = 49999;
`ifdef LED_ACTIVE_LOW_EN
    localparam logic [N_CH-1:0] POL = '1;
`else
    localparam logic [N_CH-1:0] POL = '0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en = 1'b0;
    logic              rd_en = 1'b0;
    logic [ADDR_W-1:0] addr = '0;
    logic [31:0]       wdata = '0;
    logic [31:0]       rdata;
    logic              rvalid;
    logic [N_CH-1:0]   led;
    logic              tick;

    always #5 clk = ~clk;

    led_blink_ctrl dut (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_en),
        .rd_en  (rd_en),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .rvalid (rvalid),
        .led    (led),
        .tick   (tick)
    );

    int n_vec = 0;
    int n_miss = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: registers plus tick counts since the last restart of each channel
    longint m_presc, m_since, cyc = 0;
    int     m_mode   [N_CH];
    longint m_period [N_CH];
    longint m_duty   [N_CH];
    longint m_n      [N_CH];
    longint m_pt     [N_CH];
    int     m_base   [N_CH];

    function automatic void model_reset();
        m_presc = PRESC_RST;
        m_since = 0;
        for (int c = 0; c < N_CH; c++) begin
            m_mode[c] = 0; m_period[c] = 0; m_duty[c] = 0;
            m_n[c] = 0; m_pt[c] = 0; m_base[c] = 0;
        end
    endfunction

    function automatic bit model_tick();
        return (m_since % (m_presc + 1)) == m_presc;
    endfunction

    function automatic int blink_state(int c);
        return m_base[c] ^ int'((m_n[c] / (m_period[c] + 1)) % 2);
    endfunction

    function automatic bit led_logic(int c);
        case (m_mode[c])
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return blink_state(c) != 0;
            default: return (m_pt[c] % 256) < m_duty[c];
        endcase
    endfunction

    function automatic logic [N_CH-1:0] led_vec();
        logic [N_CH-1:0] v;
        for (int c = 0; c < N_CH; c++) v[c] = led_logic(c);
        return v;
    endfunction

    function automatic logic [31:0] rd_model(int a);
        int c, o;
        if (a == 0) return 32'(m_presc);
        if (a == 1) return 32'(led_vec());
        if (a >= 4) begin
            c = (a - 4) / 4;
            o = (a - 4) % 4;
            if (c < N_CH) begin
                if (o == 0) return 32'(m_mode[c]);
                if (o == 1) return 32'(m_period[c]);
                if (o == 2) return 32'(m_duty[c]);
            end
        end
        return 32'd0;
    endfunction

    always @(posedge clk) cyc++;

    // Advance the model on each clock edge using the inputs the DUT samples
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            model_reset();
        end else begin
            int a, c, o;
            bit tk;
            tk = model_tick();
            a  = int'(addr);
            c  = (a - 4) / 4;
            o  = (a - 4) % 4;
            for (int k = 0; k < N_CH; k++) begin
                bit hit;
                hit = wr_en && a >= 4 && c == k;
                if (hit && o == 0) begin
                    m_mode[k] = int'(wdata[1:0]);
                    m_n[k] = 0; m_pt[k] = 0; m_base[k] = 0;
                end else begin
                    if (hit && o == 1) begin
                        m_base[k]   = blink_state(k);
                        m_n[k]      = 0;
                        m_period[k] = longint'(wdata[23:0]);
                    end else if (tk) begin
                        m_n[k]++;
                    end
                    if (tk) m_pt[k]++;
                    if (hit && o == 2) m_duty[k] = longint'(wdata[7:0]);
                end
            end
            if (wr_en && a == 0) begin
                m_presc = longint'(wdata[23:0]);
                m_since = 0;
            end else begin
                m_since++;
            end
        end
    end

    typedef struct {
        logic [31:0] data;
        longint      due;
    } rd_t;
    rd_t         rq[$];
    logic [31:0] last_rd = '0;

    // Monitor: per-cycle led/tick comparison and read-response scoreboard
    always @(negedge clk) begin
        rd_t e;
        check("led", led, led_vec() ^ POL);
        check("tick", tick, model_tick());
        if (!rst) last_rd = '0;
        if (rvalid) begin
            if (rq.size() == 0) begin
                check("rvalid_spurious", 1, 0);
            end else begin
                e = rq.pop_front();
                check("rd_latency", cyc, e.due);
                check("rdata", rdata, e.data);
                last_rd = e.data;
            end
        end else begin
            check("rdata_hold", rdata, last_rd);
            if (rq.size() > 0 && rq[0].due <= cyc) begin
                check("rvalid_missing", 0, 1);
                void'(rq.pop_front());
            end
        end
    end

    task automatic op(input logic w, input logic r, input int a, input logic [31:0] d);
        wr_en = w; rd_en = r; addr = a[ADDR_W-1:0]; wdata = d;
        if (r) rq.push_back('{rd_model(a), cyc + 1});
        @(posedge clk); #1;
        wr_en = 0; rd_en = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_led(input int c, input logic v, input int max, input string name,
                            output int n);
        logic [N_CH-1:0] lv;
        n = 0;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk); #1;
            lv = led ^ POL;
            if (lv[c] == v) begin n = i; return; end
        end
        check(name, 0, 1);
    endtask

    initial begin
        int n, hi;
        int a;
        logic w, r;
        logic [31:0] d;
        logic [N_CH-1:0] lv;

        rst = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_led", led, POL);
        check("rst_rvalid", rvalid, 0);
        check("rst_rdata", rdata, 0);
        rst = 1'b1;

        op(0, 1, 0, 0);
        check("rd_presc_rst", rdata, PRESC_RST);
        op(0, 1, 4, 0);
        check("rd_ctrl0_rst", rdata, 0);
        idle(2);

        // Blink: PRESC=3, PERIOD=1 -> toggle every 8 cycles
        op(1, 0, 0, 3);
        op(1, 0, 4, 2);
        op(1, 0, 5, 1);
        wait_led(0, 1, 40, "blink_first_rise", n);
        wait_led(0, 0, 40, "blink_fall", n);
        check("blink_half_low", n, 8);
        wait_led(0, 1, 40, "blink_rise", n);
        check("blink_half_high", n, 8);

        // Restart blink while lit
        op(1, 0, 4, 2);
        lv = led ^ POL;
        check("blink_restart_low", lv[0], 0);
        wait_led(0, 1, 40, "blink_restart_rise", n);
        check("blink_restart_delay", (n >= 5 && n <= 8), 1);

        // PWM at full tick rate
        op(1, 0, 0, 0);
        op(1, 0, 8, 3);
        op(1, 0, 10, 64);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            lv = led ^ POL;
            if (lv[1]) hi++;
            idle(1);
        end
        check("pwm_64", hi, 64);
        op(1, 0, 10, 0);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            lv = led ^ POL;
            if (lv[1]) hi++;
            idle(1);
        end
        check("pwm_0", hi, 0);

        // ON channel and STATUS
        op(1, 0, 4, 0);
        op(1, 0, 8, 0);
        op(1, 0, 12, 1);
        lv = led ^ POL;
        check("on_led2", lv[2], 1);
        op(0, 1, 1, 0);
        check("status", rdata, 4);
        op(1, 0, 1, 32'hF);
        op(0, 1, 1, 0);
        check("status_ro", rdata, 4);

        // Unmapped channel, same-cycle read/write, upper-bit drop
        op(1, 0, 20, 32'hFFFF_FFFF);
        op(0, 1, 20, 0);
        check("unmapped_ch4", rdata, 0);
        op(1, 0, 18, 32'h11);
        op(1, 1, 18, 32'h22);
        check("rw_old", rdata, 32'h11);
        op(0, 1, 18, 0);
        check("rw_new", rdata, 32'h22);
        op(1, 0, 18, 32'hABCD_EF55);
        op(0, 1, 18, 0);
        check("duty_trunc", rdata, 32'h55);

        // Asynchronous reset mid-count
        op(1, 0, 0, 2);
        op(1, 0, 4, 2);
        op(1, 0, 5, 0);
        idle(7);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_led", led, POL);
        check("mid_rst_rvalid", rvalid, 0);
        check("mid_rst_rdata", rdata, 0);
        check("mid_rst_tick", tick, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        op(0, 1, 0, 0);
        check("post_rst_presc", rdata, PRESC_RST);
        op(0, 1, 4, 0);
        check("post_rst_ctrl0", rdata, 0);
        op(0, 1, 14, 0);
        check("post_rst_duty2", rdata, 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            a = $urandom_range(0, 31);
            w = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            d = $urandom;
            if (a == 0) d[23:0] = 24'($urandom_range(0, 6));
            if (a >= 4 && (a - 4) % 4 == 1) d[23:0] = 24'($urandom_range(0, 5));
            op(w, r, a, d);
            idle($urandom_range(0, 6));
        end

        idle(3);
        check("rd_queue_empty", rq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/led_blink_ctrl.md
Name: led_blink_ctrl

Overview:
Parametrised multi-channel LED controller; successor to the single fixed-rate blink output of the pipeline CPU top.
- Sits on the CPU data bus as a memory-mapped peripheral.
- Drives N_CH LED pins, each independently set to OFF, ON, BLINK (programmable half-period) or PWM (programmable duty).
- A shared programmable prescaler generates the time base for all channels.

Parameters:
N_CH, 4, number of LED channels (1..7)
CNT_W, 24, width of prescaler and blink half-period counters
PWM_W, 8, PWM duty/phase width
ADDR_W, 5, word-address width of register bus
PRESC_RST, 24'd49999, prescaler reset value (1 kHz tick at 50 MHz)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset (asserted when 0)
wr_en  in  1  register write strobe, single cycle
rd_en  in  1  register read strobe, single cycle
addr  in  ADDR_W  word address
wdata  in  32  write data
rdata  out  32  read data, valid the cycle after rd_en
rvalid  out  1  high for one cycle when rdata is valid
led  out  N_CH  LED pin drive
tick  out  1  prescaler tick, for debug/bench observation

Behaviour:
- Reset (rst=0, async): all outputs 0 (led per Optional Feature); PRESC=PRESC_RST; all channel CTRL/PERIOD/DUTY=0; all counters 0.
- Address map (word):
  - 0 PRESC[CNT_W-1:0]
  - 1 STATUS: bits[N_CH-1:0] are the logical LED state; read-only, writes ignored.
  - 4+4c CTRL[1:0] of channel c
  - 5+4c PERIOD[CNT_W-1:0]
  - 6+4c DUTY[PWM_W-1:0]
  - Unmapped addresses and channels >= N_CH read 0; writes to them are ignored.
- Bus:
  - Write takes effect at the clock edge where wr_en=1.
  - Read: rdata/rvalid are registered one cycle after rd_en; rdata holds its value until the next read.
  - Simultaneous rd_en and wr_en to the same address returns the old value.
  - Unused upper wdata bits are dropped; unused upper rdata bits read 0.
- Prescaler:
  - Counter pc runs 0..PRESC. tick=1 for the one cycle where pc==PRESC, then pc wraps to 0.
  - PRESC=0 gives tick every cycle.
  - A write to PRESC clears pc.
- Channel mode encoding (CTRL): 0 OFF, 1 ON, 2 BLINK, 3 PWM.
  - OFF: led=0.
  - ON: led=1.
  - BLINK: counter bc increments on tick. On a tick with bc==PERIOD, led toggles and bc returns to 0. Toggle interval is (PERIOD+1) ticks; PERIOD=0 toggles every tick.
  - PWM: phase ph (PWM_W bits) increments on tick and wraps at 2^PWM_W-1 -> 0. led = (ph < DUTY). DUTY=0 is always off; the maximum DUTY gives 255/256 on.
- Any CTRL write (even same value) clears bc and ph and sets the blink state to 0, so a channel entering BLINK starts with led=0.
- A PERIOD write clears bc only.
- led is registered: it changes in the cycle after the tick/write that causes it.
- Mid-operation reset returns everything to reset values immediately; there is no pending-write replay.

Optional Feature:
- Macro LED_ACTIVE_LOW_EN.
  - Defined: the led pins are the inversion of the logical state; led resets to all ones.
  - Undefined: led equals the logical state; led resets to 0.
- STATUS always reports the logical (uninverted) state.

Decomposition:
- Package led_blink_pkg holds:
  - Mode encodings MODE_OFF/ON/BLINK/PWM.
  - Address constants A_PRESC=0, A_STATUS=1, A_CH_BASE=4, CH_STRIDE=4, OFF_CTRL=0, OFF_PERIOD=1, OFF_DUTY=2.
- Sub-module led_channel (one per channel, generate loop):
  - Holds CTRL/PERIOD/DUTY, bc, ph and blink state.
  - Inputs: tick and decoded write strobes. Output: logical led bit.
- Top holds the prescaler, address decode, read mux and output polarity.

Test Plan:
- Reset, then read addr 0 and addr 4 -> rdata=PRESC_RST and 0 with rvalid one cycle after rd_en; led=0 (all ones with LED_ACTIVE_LOW_EN).
- PRESC=3 -> tick every 4 cycles. Ch0 CTRL=2, PERIOD=1 -> led[0] toggles every 8 cycles, first rise 8 ticks' worth of cycles after the write (2 ticks).
- PRESC=0, ch1 CTRL=3, DUTY=64 -> over 256 cycles led[1] high exactly 64 cycles; DUTY=0 -> never high.
- Ch2 CTRL=1 -> led[2]=1 next cycle; STATUS reads 0b0100 with other channels off. Write STATUS -> value unchanged.
- Ch0 blinking; rewrite CTRL=2 while led[0]=1 -> led[0]=0 next cycle and period restarts. Assert rst mid-count -> all regs/outputs reset asynchronously.
- Write addr 20 (channel 4, N_CH=4) and read it -> rdata=0. Same-cycle read+write of ch3 DUTY -> old value returned, new value on next read.
